// File: rtl/dsd7_sram_slave.sv
// DSD7 bus block-RAM scratchpad slave with sr/cr/rb reservation support.
// Optional error response on illegal accesses: define DSD7_SRAM_ERR_EN.
module dsd7_sram_slave #(
  parameter logic [31:0] ADDR_BASE  = 32'hFFFC0000,
  parameter logic [31:0] ADDR_MASK  = 32'hFFFFF000,
  parameter int unsigned DEPTH_LOG2 = 12
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        vpa_i,
  input  logic        vda_i,
  input  logic        wr_i,
  input  logic [1:0]  sel_i,
  input  logic [31:0] adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  input  logic        sr_i,
  input  logic        cr_i,
  output logic        rb_o
`ifdef DSD7_SRAM_ERR_EN
  ,
  output logic        err_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RD, S_ACK} state_t;

  state_t                r_state;
  logic [31:0]           r_dat;
  logic [31:0]           r_rdata;
  logic                  r_ack;
  logic                  r_rb;
  logic                  r_resv_valid;
  logic [DEPTH_LOG2-1:0] r_resv_idx;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_cs;
  logic                  w_err;
  logic                  w_resv_hit;
  logic                  w_wr_go;
  logic                  w_we;
  logic [31:0]           mem [0:(1<<DEPTH_LOG2)-1];

  assign w_cs       = cyc_i & stb_i & (vpa_i | vda_i) & ((adr_i & ADDR_MASK) == ADDR_BASE);
  assign w_idx      = adr_i[DEPTH_LOG2-1:0];
  assign w_resv_hit = r_resv_valid & (r_resv_idx == w_idx);

`ifdef DSD7_SRAM_ERR_EN
  logic r_err;
  assign w_err = (sel_i == 2'b00) | (vpa_i & wr_i);
  assign err_o = r_err & w_cs;
`else
  assign w_err = 1'b0;
`endif

  assign w_wr_go = (r_state == S_IDLE) & w_cs & wr_i & ~w_err;
  assign w_we    = w_wr_go & (~cr_i | w_resv_hit);

  // RAM kept out of the reset domain so it maps onto block RAM; the read
  // is issued every cycle and only consumed from RD.
  always_ff @(posedge clk_i) begin
    if (w_we & sel_i[0]) mem[w_idx][15:0]  <= dat_i[15:0];
    if (w_we & sel_i[1]) mem[w_idx][31:16] <= dat_i[31:16];
    r_rdata <= mem[w_idx];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= S_IDLE;
      r_dat        <= '0;
      r_ack        <= 1'b0;
      r_rb         <= 1'b0;
      r_resv_valid <= 1'b0;
      r_resv_idx   <= '0;
`ifdef DSD7_SRAM_ERR_EN
      r_err        <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_cs) begin
            if (w_err) begin
`ifdef DSD7_SRAM_ERR_EN
              r_err   <= 1'b1;
`endif
              r_state <= S_ACK;
            end else if (wr_i) begin
              r_ack   <= 1'b1;
              r_rb    <= cr_i & w_resv_hit;
              if (cr_i || (r_resv_idx == w_idx)) r_resv_valid <= 1'b0;
              r_state <= S_ACK;
            end else begin
              if (sr_i) begin
                r_resv_valid <= 1'b1;
                r_resv_idx   <= w_idx;
              end
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          if (cyc_i & stb_i) begin
            r_dat   <= r_rdata;
            r_ack   <= 1'b1;
            r_state <= S_ACK;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_ACK: begin
          if (!stb_i) begin
            r_dat   <= '0;
            r_ack   <= 1'b0;
            r_rb    <= 1'b0;
`ifdef DSD7_SRAM_ERR_EN
            r_err   <= 1'b0;
`endif
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Gated by select so the outputs can be OR-combined with other slaves.
  assign ack_o = r_ack & w_cs;
  assign rb_o  = r_rb & w_cs;
  assign dat_o = w_cs ? r_dat : '0;

endmodule

// File: tb/tb_dsd7_sram_slave.sv
// Self-checking bench for dsd7_sram_slave: directed vector table, corner
// sequences, and randomized traffic against a behavioural reference model.
module tb_dsd7_sram_slave;
  localparam logic [31:0] BASE = 32'hFFFC0000;
`ifdef DSD7_SRAM_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, vpa = 1'b0, vda = 1'b0, wr = 1'b0;
  logic [1:0]  sel = 2'b00;
  logic [31:0] adr = '0, dati = '0;
  logic        sr = 1'b0, cr = 1'b0;
  logic [31:0] dato;
  logic        ack, rb, errs;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dsd7_sram_slave #(.ADDR_BASE(BASE), .ADDR_MASK(32'hFFFFF000), .DEPTH_LOG2(12)) dut (
    .clk_i(clk), .rst_i(rst), .cyc_i(cyc), .stb_i(stb), .vpa_i(vpa), .vda_i(vda),
    .wr_i(wr), .sel_i(sel), .adr_i(adr), .dat_i(dati), .dat_o(dato), .ack_o(ack),
    .sr_i(sr), .cr_i(cr), .rb_o(rb)
`ifdef DSD7_SRAM_ERR_EN
    , .err_o(errs)
`endif
  );
`ifndef DSD7_SRAM_ERR_EN
  assign errs = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // One complete bus transfer; lat = clocks until ack/err, 0 if neither arrives.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s, input logic srv, input logic crv, input logic pa,
                      output int lat, output logic [31:0] rd, output logic rbv,
                      output logic ackv, output logic errv);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; vda = 1'b1; vpa = pa; wr = w; adr = a; dati = d;
    sel = s; sr = srv; cr = crv;
    lat = 0; rd = '0; rbv = 1'b0; ackv = 1'b0; errv = 1'b0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (ack || errs) begin
        lat = c; rd = dato; rbv = rb; ackv = ack; errv = errs;
        break;
      end
    end
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; vda = 1'b0; vpa = 1'b0; wr = 1'b0; sr = 1'b0; cr = 1'b0; sel = 2'b00;
    @(posedge clk); #1;
  endtask

  // Reference model: word-level memory plus a single reservation.
  logic [31:0] ref_mem [int unsigned];
  bit          rv = 1'b0;
  int unsigned ri = 0;

  task automatic model(input logic w, input int unsigned idx, input logic [31:0] d,
                       input logic [1:0] s, input logic srv, input logic crv, input logic pa,
                       output int elat, output logic [31:0] edat, output logic erb,
                       output logic eerr);
    logic [31:0] m;
    bit ok;
    edat = '0; erb = 1'b0; eerr = 1'b0;
    if (ERR_EN && (s == 2'b00 || (pa && w))) begin
      eerr = 1'b1; elat = 1;
    end else if (w) begin
      elat = 1;
      ok = !crv || (rv && ri == idx);
      if (ok) begin
        m = {{16{s[1]}}, {16{s[0]}}};
        ref_mem[idx] = (ref_mem[idx] & ~m) | (d & m);
      end
      erb = crv && ok;
      if (crv || ri == idx) rv = 1'b0;
    end else begin
      elat = 2;
      edat = ref_mem[idx];
      if (srv) begin rv = 1'b1; ri = idx; end
    end
  endtask

  typedef struct {
    logic        w;
    logic [11:0] off;
    logic [31:0] d;
    logic [1:0]  s;
    logic        srv, crv;
    int          elat;
    logic [31:0] edat;
    logic        erb;
  } vec_t;

  vec_t tv[$];

  initial begin
    int lat;
    logic [31:0] rd;
    logic rbv, ackv, errv;
    int elat;
    logic [31:0] edat;
    logic erb, eerr;
    int unsigned pool[16];

    tv.push_back('{1'b1, 12'h010, 32'hDEADBEEF, 2'b11, 1'b0, 1'b0, 1, 32'h0, 1'b0});
    tv.push_back('{1'b0, 12'h010, 32'h0,        2'b11, 1'b0, 1'b0, 2, 32'hDEADBEEF, 1'b0});
    tv.push_back('{1'b1, 12'h011, 32'hFFFFFFFF, 2'b11, 1'b0, 1'b0, 1, 32'h0, 1'b0});
    tv.push_back('{1'b1, 12'h011, 32'h12345678, 2'b01, 1'b0, 1'b0, 1, 32'h0, 1'b0});
    tv.push_back('{1'b0, 12'h011, 32'h0,        2'b11, 1'b0, 1'b0, 2, 32'hFFFF5678, 1'b0});
    tv.push_back('{1'b1, 12'h011, 32'hABCD0000, 2'b10, 1'b0, 1'b0, 1, 32'h0, 1'b0});
    tv.push_back('{1'b0, 12'h011, 32'h0,        2'b01, 1'b0, 1'b1, 2, 32'hABCD5678, 1'b0});
    tv.push_back('{1'b1, 12'h020, 32'h00000000, 2'b11, 1'b0, 1'b0, 1, 32'h0, 1'b0});
    tv.push_back('{1'b0, 12'h020, 32'h0,        2'b11, 1'b1, 1'b0, 2, 32'h00000000, 1'b0});
    tv.push_back('{1'b1, 12'h020, 32'hA5A5A5A5, 2'b11, 1'b0, 1'b1, 1, 32'h0, 1'b1});
    tv.push_back('{1'b0, 12'h020, 32'h0,        2'b11, 1'b0, 1'b0, 2, 32'hA5A5A5A5, 1'b0});
    tv.push_back('{1'b1, 12'h020, 32'h5A5A5A5A, 2'b11, 1'b0, 1'b1, 1, 32'h0, 1'b0});
    tv.push_back('{1'b0, 12'h020, 32'h0,        2'b11, 1'b0, 1'b0, 2, 32'hA5A5A5A5, 1'b0});
    tv.push_back('{1'b1, 12'h030, 32'h11111111, 2'b11, 1'b0, 1'b0, 1, 32'h0, 1'b0});
    tv.push_back('{1'b0, 12'h030, 32'h0,        2'b11, 1'b1, 1'b0, 2, 32'h11111111, 1'b0});
    tv.push_back('{1'b1, 12'h030, 32'h22222222, 2'b11, 1'b0, 1'b0, 1, 32'h0, 1'b0});
    tv.push_back('{1'b1, 12'h030, 32'h33333333, 2'b11, 1'b0, 1'b1, 1, 32'h0, 1'b0});
    tv.push_back('{1'b0, 12'h030, 32'h0,        2'b11, 1'b0, 1'b0, 2, 32'h22222222, 1'b0});
    tv.push_back('{1'b1, 12'h040, 32'h44444444, 2'b11, 1'b0, 1'b0, 1, 32'h0, 1'b0});
    tv.push_back('{1'b0, 12'h040, 32'h0,        2'b11, 1'b1, 1'b0, 2, 32'h44444444, 1'b0});
    tv.push_back('{1'b1, 12'h041, 32'h41414141, 2'b11, 1'b0, 1'b0, 1, 32'h0, 1'b0});
    tv.push_back('{1'b1, 12'h040, 32'h40404040, 2'b11, 1'b0, 1'b1, 1, 32'h0, 1'b1});
    tv.push_back('{1'b0, 12'h040, 32'h0,        2'b11, 1'b0, 1'b0, 2, 32'h40404040, 1'b0});
    tv.push_back('{1'b1, 12'h050, 32'h55555555, 2'b11, 1'b1, 1'b0, 1, 32'h0, 1'b0});
    tv.push_back('{1'b1, 12'h050, 32'h66666666, 2'b11, 1'b0, 1'b1, 1, 32'h0, 1'b0});
    tv.push_back('{1'b0, 12'h050, 32'h0,        2'b11, 1'b0, 1'b0, 2, 32'h55555555, 1'b0});

    rst = 1'b1;
    #1;
    chk("reset_ack", 32'(ack), 32'h0);
    chk("reset_rb", 32'(rb), 32'h0);
    chk("reset_dat", dato, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;

    foreach (tv[i]) begin
      xfer(tv[i].w, BASE + 32'(tv[i].off), tv[i].d, tv[i].s, tv[i].srv, tv[i].crv, 1'b0,
           lat, rd, rbv, ackv, errv);
      chk($sformatf("vec%0d_lat", i), 32'(lat), 32'(tv[i].elat));
      chk($sformatf("vec%0d_rb", i), 32'(rbv), 32'(tv[i].erb));
      if (!tv[i].w) chk($sformatf("vec%0d_dat", i), rd, tv[i].edat);
    end

    // Acknowledge held while stb stays high.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; vda = 1'b1; wr = 1'b0; sel = 2'b11; adr = BASE + 32'h10;
    repeat (2) @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("hold_ack", 32'(ack), 32'h1);
      chk("hold_dat", dato, 32'hDEADBEEF);
    end
    @(negedge clk); cyc = 1'b0; stb = 1'b0; vda = 1'b0;
    @(posedge clk); #1;
    chk("hold_release", 32'(ack), 32'h0);

    // Empty lane mask.
    xfer(1'b1, BASE + 32'h10, 32'h0, 2'b00, 1'b0, 1'b0, 1'b0, lat, rd, rbv, ackv, errv);
    chk("sel0_wr_lat", 32'(lat), 32'h1);
    chk("sel0_wr_err", 32'(errv), 32'(ERR_EN));
    chk("sel0_wr_ack", 32'(ackv), 32'(!ERR_EN));
    xfer(1'b0, BASE + 32'h10, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, lat, rd, rbv, ackv, errv);
    chk("sel0_unchanged", rd, 32'hDEADBEEF);

    // Outside the window: silent, and memory at the aliased index untouched.
    xfer(1'b1, BASE, 32'h77777777, 2'b11, 1'b0, 1'b0, 1'b0, lat, rd, rbv, ackv, errv);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; vda = 1'b1; wr = 1'b1; sel = 2'b11; adr = 32'h00001000; dati = '0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("oow_wr_ack", 32'(ack), 32'h0);
    end
    @(negedge clk); wr = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      chk("oow_rd_ack", 32'(ack | rb), 32'h0);
      chk("oow_rd_dat", dato, 32'h0);
    end
    @(negedge clk); cyc = 1'b0; stb = 1'b0; vda = 1'b0;
    @(posedge clk); #1;
    xfer(1'b0, BASE, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, lat, rd, rbv, ackv, errv);
    chk("oow_alias_dat", rd, 32'h77777777);

    // Strobe dropped during the read wait state.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; vda = 1'b1; wr = 1'b0; sel = 2'b11; adr = BASE + 32'h10;
    @(posedge clk); #1;
    chk("abort_early_ack", 32'(ack), 32'h0);
    @(negedge clk); stb = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("abort_ack", 32'(ack), 32'h0);
      chk("abort_dat", dato, 32'h0);
    end
    @(negedge clk); cyc = 1'b0; vda = 1'b0;
    xfer(1'b0, BASE + 32'h10, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, lat, rd, rbv, ackv, errv);
    chk("after_abort_lat", 32'(lat), 32'h2);
    chk("after_abort_dat", rd, 32'hDEADBEEF);

    // Reset in RD with a reservation held.
    xfer(1'b1, BASE + 32'h60, 32'hCAFEF00D, 2'b11, 1'b0, 1'b0, 1'b0, lat, rd, rbv, ackv, errv);
    xfer(1'b0, BASE + 32'h60, 32'h0, 2'b11, 1'b1, 1'b0, 1'b0, lat, rd, rbv, ackv, errv);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; vda = 1'b1; wr = 1'b0; sel = 2'b11; adr = BASE + 32'h60;
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b1; #1;
    chk("rst_rd_ack", 32'(ack), 32'h0);
    chk("rst_rd_dat", dato, 32'h0);
    cyc = 1'b0; stb = 1'b0; vda = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    xfer(1'b1, BASE + 32'h60, 32'h0BAD0BAD, 2'b11, 1'b0, 1'b1, 1'b0, lat, rd, rbv, ackv, errv);
    chk("rst_cr_rb", 32'(rbv), 32'h0);
    xfer(1'b0, BASE + 32'h60, 32'h0, 2'b11, 1'b0, 1'b0, 1'b0, lat, rd, rbv, ackv, errv);
    chk("rst_cr_mem", rd, 32'hCAFEF00D);

    // Randomized traffic against the model, starting from a clean reservation.
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    rv = 1'b0;
    for (int i = 0; i < 16; i++) begin
      pool[i] = 32'h100 + 32'(i) * 37;
      model(1'b1, pool[i], $urandom, 2'b11, 1'b0, 1'b0, 1'b0, elat, edat, erb, eerr);
      xfer(1'b1, BASE + pool[i], ref_mem[pool[i]], 2'b11, 1'b0, 1'b0, 1'b0,
           lat, rd, rbv, ackv, errv);
      chk("init_lat", 32'(lat), 32'(elat));
    end
    for (int i = 0; i < 300; i++) begin
      logic        w, srv, crv, pa;
      logic [1:0]  s;
      logic [31:0] d;
      int unsigned idx;
      w   = 1'($urandom_range(0, 1));
      s   = 2'($urandom_range(0, 3));
      srv = 1'($urandom_range(0, 1));
      crv = 1'($urandom_range(0, 1));
      pa  = ($urandom_range(0, 7) == 0);
      d   = $urandom;
      idx = pool[$urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : $urandom_range(0, 2)];
      model(w, idx, d, s, srv, crv, pa, elat, edat, erb, eerr);
      xfer(w, BASE + idx, d, s, srv, crv, pa, lat, rd, rbv, ackv, errv);
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(elat));
      chk($sformatf("rnd%0d_rb", i), 32'(rbv), 32'(erb));
      chk($sformatf("rnd%0d_err", i), 32'(errv), 32'(eerr));
      if (!w || eerr) chk($sformatf("rnd%0d_dat", i), rd, edat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
